// File: rtl/btn_debounce.sv
// Push-button debouncer: two-flop synchroniser, stability-qualified edge FSM,
// registered level plus press/release/long-press strobes. Long press is built only with `BTN_LONG_PRESS_EN.
module btn_debounce #(
    parameter int unsigned COUNT_WIDTH     = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 1152000,
    parameter int unsigned LONG_CYCLES     = 115200000
) (
    input  logic clk,
    input  logic s_reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] DB_LAST  = COUNT_WIDTH'(DEBOUNCE_CYCLES - 32'd1);

    logic                   r_sync_meta;
    logic                   r_sync_q;
    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_db_cnt;
    logic                   r_btn_level;
    logic                   r_press_pulse;
    logic                   r_release_pulse;
    logic                   w_db_done;

    assign w_db_done = (r_db_cnt == DB_LAST);

    // Two-flop synchroniser bringing the raw button into the clk domain
    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_sync_meta <= 1'b0;
            r_sync_q    <= 1'b0;
        end else begin
            r_sync_meta <= btn_in;
            r_sync_q    <= r_sync_meta;
        end
    end

    // Debounce FSM: db_cnt restarts on every state entry, strobes last one cycle
    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_state         <= RELEASED;
            r_db_cnt        <= CNT_ZERO;
            r_btn_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (r_sync_q) begin
                        r_state  <= PRESS_CHK;
                        r_db_cnt <= CNT_ZERO;
                    end
                end
                PRESS_CHK: begin
                    if (!r_sync_q) begin
                        r_state  <= RELEASED;
                        r_db_cnt <= CNT_ZERO;
                    end else if (w_db_done) begin
                        r_state       <= PRESSED;
                        r_db_cnt      <= CNT_ZERO;
                        r_btn_level   <= 1'b1;
                        r_press_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!r_sync_q) begin
                        r_state  <= RELEASE_CHK;
                        r_db_cnt <= CNT_ZERO;
                    end
                end
                RELEASE_CHK: begin
                    if (r_sync_q) begin
                        r_state  <= PRESSED;
                        r_db_cnt <= CNT_ZERO;
                    end else if (w_db_done) begin
                        r_state         <= RELEASED;
                        r_db_cnt        <= CNT_ZERO;
                        r_btn_level     <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state     <= RELEASED;
                    r_db_cnt    <= CNT_ZERO;
                    r_btn_level <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [COUNT_WIDTH-1:0] LONG_LAST = COUNT_WIDTH'(LONG_CYCLES - 32'd1);

    logic [COUNT_WIDTH-1:0] r_hold_cnt;
    logic                   r_long_done;
    logic                   r_long_pulse;
    logic                   w_press_accept;
    logic                   w_hold_live;

    assign w_press_accept = (r_state == PRESS_CHK) && r_sync_q && w_db_done;
    // The release strobe cycle still counts: the hold may have saturated on the release edge
    assign w_hold_live    = r_btn_level | r_release_pulse;

    // Hold counter: saturating, cleared only on an accepted press, fires long_pulse once per press
    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_hold_cnt   <= CNT_ZERO;
            r_long_done  <= 1'b0;
            r_long_pulse <= 1'b0;
        end else if (w_press_accept) begin
            r_hold_cnt   <= CNT_ZERO;
            r_long_done  <= 1'b0;
            r_long_pulse <= 1'b0;
        end else begin
            r_long_pulse <= 1'b0;
            if (r_btn_level && (r_hold_cnt != LONG_LAST)) begin
                r_hold_cnt <= r_hold_cnt + CNT_ONE;
            end
            if (w_hold_live && (r_hold_cnt == LONG_LAST) && !r_long_done) begin
                r_long_pulse <= 1'b1;
                r_long_done  <= 1'b1;
            end
        end
    end

    assign long_pulse = r_long_pulse;
`else
    // LONG_CYCLES is accepted but has no effect in this build
    if (LONG_CYCLES == 32'd0) begin : g_long_ignored
    end

    assign long_pulse = 1'b0;
`endif

endmodule
